// File: rtl/ntt_bf_sequencer_if.sv
// Control and coefficient-memory bundle of the NTT butterfly sequencer.
// master = sequencer side, slave = top FSM / memory side.
interface ntt_bf_sequencer_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              start;
  logic              fwd;
  logic [10:0]       param_n;
  logic              busy;
  logic              done;
  logic              err;
  logic              ntt_start_o;
  logic              fwd_ntt_o;
  logic              first_rounds_o;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [ADDR_W:0]   tw_idx;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr_a;
  logic [ADDR_W-1:0] wr_addr_b;

  modport master (
    input  start, fwd, param_n,
    output busy, done, err, ntt_start_o, fwd_ntt_o, first_rounds_o,
    output rd_en, rd_addr_a, rd_addr_b, tw_idx,
    output wr_en, wr_addr_a, wr_addr_b
  );

  modport slave (
    output start, fwd, param_n,
    input  busy, done, err, ntt_start_o, fwd_ntt_o, first_rounds_o,
    input  rd_en, rd_addr_a, rd_addr_b, tw_idx,
    input  wr_en, wr_addr_a, wr_addr_b
  );
endinterface

// File: rtl/ntt_bf_sequencer.sv
// Walks all NTT stages for n = 256/512/1024, issuing butterfly read pairs and
// twiddle indices, and replays every pair as a write-back D cycles later.
module ntt_bf_sequencer #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BF_LAT = 1
) (
  input logic                 clk,
  input logic                 rst_n,
  ntt_bf_sequencer_if.master  bus
);

  localparam int unsigned TW_W = ADDR_W + 1;
  localparam int unsigned D    = RD_LAT + BF_LAT;
  localparam int unsigned DCW  = (D > 1) ? $clog2(D) : 1;
  localparam int unsigned LGW  = 4;
  localparam int unsigned PW   = 1 + 2 * ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              fwd_q, fwd_d;
  logic              valid_q, valid_d;
  logic [LGW-1:0]    lg_q, lg_d;
  logic [LGW-1:0]    pos_q, pos_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [DCW-1:0]    drain_q, drain_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              ntt_start_q, ntt_start_d;
  logic              first_rounds_q, first_rounds_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_a_q, rd_a_d;
  logic [ADDR_W-1:0] rd_b_q, rd_b_d;
  logic [TW_W-1:0]   tw_q, tw_d;

  logic [PW-1:0]     wb_q [D];
  logic [PW-1:0]     wb_d [D];

  logic [ADDR_W-1:0] half_m1;
  logic              intra;
  logic              in_stage;
  logic [LGW-1:0]    s_idx;
  logic [LGW-1:0]    k_sh;
  logic [ADDR_W-1:0] mask;
  logic [ADDR_W-1:0] a_c;
  logic [ADDR_W-1:0] b_c;
  logic [TW_W-1:0]   tw_c;

  // Next-state, counters, and registered-output decode from the next state
  always_comb begin
    state_d = state_q;
    fwd_d   = fwd_q;
    valid_d = valid_q;
    lg_d    = lg_q;
    pos_d   = pos_q;
    j_d     = j_q;
    drain_d = drain_q;
    half_m1 = (ADDR_W'(1) << (lg_q - 4'd1)) - ADDR_W'(1);

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d = S_INIT;
          fwd_d   = bus.fwd;
          valid_d = 1'b1;
          case (bus.param_n)
            11'd256:  lg_d = 4'd7;
            11'd512:  lg_d = 4'd8;
            11'd1024: lg_d = 4'd9;
            default: begin
              lg_d    = 4'd0;
              valid_d = 1'b0;
            end
          endcase
        end
      end
      S_INIT: begin
        if (valid_q) begin
          state_d = S_RUN;
          pos_d   = '0;
          j_d     = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (j_q == half_m1) begin
          state_d = S_DRAIN;
          drain_d = '0;
        end else begin
          j_d = j_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (drain_q == DCW'(D - 1)) begin
          if (pos_q == lg_q) begin
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
            pos_d   = pos_q + 4'd1;
            j_d     = '0;
          end
        end else begin
          drain_d = drain_q + DCW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Stage position -> word stage s, or the intra-word stage
    intra = fwd_d ? (pos_d == lg_d) : (pos_d == 4'd0);
    s_idx = fwd_d ? pos_d : (lg_d - pos_d);
    k_sh  = lg_d - 4'd1 - s_idx;
    mask  = (ADDR_W'(1) << k_sh) - ADDR_W'(1);
    if (intra) begin
      a_c  = {j_d[ADDR_W-2:0], 1'b0};
      b_c  = a_c | ADDR_W'(1);
      tw_c = (TW_W'(1) << lg_d) + TW_W'({j_d, 1'b0});
    end else begin
      a_c  = ((j_d >> k_sh) << (k_sh + 4'd1)) | (j_d & mask);
      b_c  = a_c | (ADDR_W'(1) << k_sh);
      tw_c = (TW_W'(1) << s_idx) + TW_W'(j_d >> k_sh);
    end

    in_stage       = (state_d == S_RUN) || (state_d == S_DRAIN);
    busy_d         = (state_d == S_INIT) || in_stage;
    done_d         = (state_d == S_DONE);
    err_d          = (state_d == S_INIT) && !valid_d;
    ntt_start_d    = (state_d == S_INIT) && valid_d;
    rd_en_d        = (state_d == S_RUN);
    rd_a_d         = rd_en_d ? a_c : '0;
    rd_b_d         = rd_en_d ? b_c : '0;
    tw_d           = in_stage ? tw_c : '0;
    first_rounds_d = in_stage && !intra;
  end

  // Write-back replay: read strobe and addresses delayed D cycles
  always_comb begin
    wb_d[0] = {rd_en_q, rd_a_q, rd_b_q};
    for (int unsigned i = 1; i < D; i++) begin
      wb_d[i] = wb_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      fwd_q          <= 1'b0;
      valid_q        <= 1'b0;
      lg_q           <= '0;
      pos_q          <= '0;
      j_q            <= '0;
      drain_q        <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      ntt_start_q    <= 1'b0;
      first_rounds_q <= 1'b0;
      rd_en_q        <= 1'b0;
      rd_a_q         <= '0;
      rd_b_q         <= '0;
      tw_q           <= '0;
      for (int unsigned i = 0; i < D; i++) begin
        wb_q[i] <= '0;
      end
    end else begin
      state_q        <= state_d;
      fwd_q          <= fwd_d;
      valid_q        <= valid_d;
      lg_q           <= lg_d;
      pos_q          <= pos_d;
      j_q            <= j_d;
      drain_q        <= drain_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      ntt_start_q    <= ntt_start_d;
      first_rounds_q <= first_rounds_d;
      rd_en_q        <= rd_en_d;
      rd_a_q         <= rd_a_d;
      rd_b_q         <= rd_b_d;
      tw_q           <= tw_d;
      wb_q           <= wb_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.err            = err_q;
  assign bus.ntt_start_o    = ntt_start_q;
  assign bus.fwd_ntt_o      = fwd_q;
  assign bus.first_rounds_o = first_rounds_q;
  assign bus.rd_en          = rd_en_q;
  assign bus.rd_addr_a      = rd_a_q;
  assign bus.rd_addr_b      = rd_b_q;
  assign bus.tw_idx         = tw_q;
  assign {bus.wr_en, bus.wr_addr_a, bus.wr_addr_b} = wb_q[D-1];

endmodule

// File: tb/tb_ntt_bf_sequencer.sv
// Directed bench for ntt_bf_sequencer: table of full runs checked cycle by
// cycle against a schedule model, plus error, done-restart and reset sequences.
module tb_ntt_bf_sequencer;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned RD_LAT = 1;
  localparam int unsigned BF_LAT = 1;
  localparam int          D      = RD_LAT + BF_LAT;
  localparam int          MAXC   = 2700;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  ntt_bf_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  ntt_bf_sequencer #(
    .ADDR_W (ADDR_W),
    .RD_LAT (RD_LAT),
    .BF_LAT (BF_LAT)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp   = 0;
  int n_bad   = 0;
  int cur_cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 30)
        $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cur_cyc, act, exp);
    end
  endtask

  typedef struct {
    bit rd;
    int a;
    int b;
    int tw;
    bit fr;
    bit act;
  } ev_t;

  ev_t ev [MAXC];

  typedef struct {
    int n;
    bit f;
    int exp_done;
    int a0;
    int b0;
    int tw0;
    int fr0;
  } vec_t;

  // Expected issue schedule; returns the done cycle
  task automatic build(input int n, input bit f, output int last);
    int w, l, half, c, s, dd, a, b, tw;
    bit intra, fr;
    w    = n / 2;
    l    = $clog2(w);
    half = w / 2;
    for (int i = 0; i < MAXC; i++) ev[i] = '{default: 0};
    c = 2;
    for (int p = 0; p <= l; p++) begin
      intra = f ? (p == l) : (p == 0);
      s     = f ? p : (l - p);
      for (int j = 0; j < half; j++) begin
        if (intra) begin
          a = 2 * j; b = 2 * j + 1; tw = w + 2 * j; fr = 1'b0;
        end else begin
          dd = w >> (s + 1);
          a  = (j / dd) * 2 * dd + (j % dd);
          b  = a + dd;
          tw = (1 << s) + j / dd;
          fr = 1'b1;
        end
        ev[c] = '{1'b1, a, b, tw, fr, 1'b1};
        c++;
      end
      for (int q = 0; q < D; q++) begin
        ev[c]    = ev[c-1];
        ev[c].rd = 1'b0;
        c++;
      end
    end
    last = c;
  endtask

  task automatic check_cycle(input int k, input int last, input bit f);
    chk("busy", int'(bus.busy), int'(k < last));
    chk("done", int'(bus.done), int'(k == last));
    chk("err", int'(bus.err), 0);
    chk("ntt_start", int'(bus.ntt_start_o), int'(k == 1));
    chk("rd_en", int'(bus.rd_en), int'(ev[k].rd));
    if (ev[k].rd) begin
      chk("rd_addr_a", int'(bus.rd_addr_a), ev[k].a);
      chk("rd_addr_b", int'(bus.rd_addr_b), ev[k].b);
    end
    if (k < last && ev[k].act) begin
      chk("tw_idx", int'(bus.tw_idx), ev[k].tw);
      chk("first_rounds", int'(bus.first_rounds_o), int'(ev[k].fr));
      chk("fwd_ntt", int'(bus.fwd_ntt_o), int'(f));
    end
    if (k >= D) begin
      chk("wr_en", int'(bus.wr_en), int'(ev[k-D].rd));
      if (ev[k-D].rd) begin
        chk("wr_addr_a", int'(bus.wr_addr_a), ev[k-D].a);
        chk("wr_addr_b", int'(bus.wr_addr_b), ev[k-D].b);
      end
    end else begin
      chk("wr_en", int'(bus.wr_en), 0);
    end
  endtask

  // One full run; a stray start with a bad param_n is injected mid-run
  task automatic run_vec(input vec_t v);
    int last, done_at;
    build(v.n, v.f, last);
    @(negedge clk);
    cur_cyc     = 0;
    bus.param_n = 11'(v.n);
    bus.fwd     = v.f;
    bus.start   = 1'b1;
    done_at     = -1;
    for (int k = 1; k <= last + 2; k++) begin
      @(negedge clk);
      cur_cyc = k;
      if (k == 1) bus.start = 1'b0;
      check_cycle(k, last, v.f);
      if (bus.done && done_at < 0) done_at = k;
      if (k == 2) begin
        chk("first_a", int'(bus.rd_addr_a), v.a0);
        chk("first_b", int'(bus.rd_addr_b), v.b0);
        chk("first_tw", int'(bus.tw_idx), v.tw0);
        chk("first_fr", int'(bus.first_rounds_o), v.fr0);
      end
      if (k == 20) begin
        bus.start   = 1'b1;
        bus.param_n = 11'd300;
        bus.fwd     = ~v.f;
      end
      if (k == 21) bus.start = 1'b0;
    end
    chk("done_cycle", done_at, v.exp_done);
  endtask

  vec_t tbl [6];
  int   done_at;

  initial begin
    tbl[0] = '{256,  1'b1, 530,  0, 64,  1,   1};
    tbl[1] = '{256,  1'b0, 530,  0, 1,   128, 0};
    tbl[2] = '{512,  1'b1, 1172, 0, 128, 1,   1};
    tbl[3] = '{512,  1'b0, 1172, 0, 1,   256, 0};
    tbl[4] = '{1024, 1'b1, 2582, 0, 256, 1,   1};
    tbl[5] = '{1024, 1'b0, 2582, 0, 1,   512, 0};

    bus.start   = 1'b0;
    bus.fwd     = 1'b0;
    bus.param_n = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_rd_en", int'(bus.rd_en), 0);
    chk("rst_wr_en", int'(bus.wr_en), 0);
    chk("rst_tw", int'(bus.tw_idx), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_vec(tbl[i]);

    // Unsupported ring size: err pulse only
    @(negedge clk);
    cur_cyc     = 0;
    bus.param_n = 11'd300;
    bus.fwd     = 1'b1;
    bus.start   = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      cur_cyc = k;
      if (k == 1) bus.start = 1'b0;
      chk("bad_err", int'(bus.err), int'(k == 1));
      chk("bad_done", int'(bus.done), 0);
      chk("bad_rd_en", int'(bus.rd_en), 0);
      chk("bad_wr_en", int'(bus.wr_en), 0);
      chk("bad_ntt_start", int'(bus.ntt_start_o), 0);
      if (k >= 2) chk("bad_busy", int'(bus.busy), 0);
    end

    // Start during DONE is ignored, accepted on the next IDLE cycle
    @(negedge clk);
    cur_cyc     = 0;
    bus.param_n = 11'd256;
    bus.fwd     = 1'b1;
    bus.start   = 1'b1;
    done_at     = -1;
    for (int k = 1; k <= 1000; k++) begin
      @(negedge clk);
      cur_cyc = k;
      if (k == 1) bus.start = 1'b0;
      if (bus.done) begin
        done_at = k;
        break;
      end
    end
    chk("seq_done_cycle", done_at, 530);
    bus.param_n = 11'd512;
    bus.start   = 1'b1;
    @(negedge clk);
    chk("done_start_ignored_busy", int'(bus.busy), 0);
    chk("done_start_ignored_nst", int'(bus.ntt_start_o), 0);
    @(negedge clk);
    cur_cyc = 1;
    chk("idle_start_busy", int'(bus.busy), 1);
    chk("idle_start_nst", int'(bus.ntt_start_o), 1);
    bus.start = 1'b0;

    // Reset at cycle 100 of an n=512 run
    for (int k = 2; k <= 100; k++) begin
      @(negedge clk);
      cur_cyc = k;
    end
    chk("pre_rst_rd_en", int'(bus.rd_en), 1);
    chk("pre_rst_wr_en", int'(bus.wr_en), 1);
    rst_n = 1'b0;
    #1;
    chk("ar_busy", int'(bus.busy), 0);
    chk("ar_done", int'(bus.done), 0);
    chk("ar_err", int'(bus.err), 0);
    chk("ar_ntt_start", int'(bus.ntt_start_o), 0);
    chk("ar_fwd_ntt", int'(bus.fwd_ntt_o), 0);
    chk("ar_first_rounds", int'(bus.first_rounds_o), 0);
    chk("ar_rd_en", int'(bus.rd_en), 0);
    chk("ar_rd_a", int'(bus.rd_addr_a), 0);
    chk("ar_rd_b", int'(bus.rd_addr_b), 0);
    chk("ar_tw", int'(bus.tw_idx), 0);
    chk("ar_wr_en", int'(bus.wr_en), 0);
    chk("ar_wr_a", int'(bus.wr_addr_a), 0);
    chk("ar_wr_b", int'(bus.wr_addr_b), 0);
    repeat (3) begin
      @(negedge clk);
      chk("in_rst_wr_en", int'(bus.wr_en), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(tbl[2]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
